// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port fixed-latency memory (optional ARB_PERF_CNT_EN grant counters)
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_if_grants_o,
  output logic [31:0]       perf_d_grants_o,
  output logic [31:0]       perf_conflicts_o,
`endif
  output logic              stall_if_o,
  output logic              stall_mem_o
);

  // Latency counter only ever holds MEM_LAT-1 down to 0.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              gnt_d_q, gnt_d_d;     // 1: data port owns the in-flight access
  logic              gnt_we_q, gnt_we_d;   // in-flight access is a write
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_if, grant_d;
  logic              starve_at_max;

  assign starve_at_max = (starve_q == STV_W'(STARVE_MAX));

  // Next-state, arbitration and memory strobe generation.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    starve_d    = starve_q;
    gnt_d_d     = gnt_d_q;
    gnt_we_d    = gnt_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Data wins unless fetch has waited through STARVE_MAX data grants.
        if (d_req_i && !(if_req_i && starve_at_max)) begin
          grant_d = 1'b1;
        end else if (if_req_i) begin
          grant_if = 1'b1;
        end
        if (grant_d) begin
          gnt_d_d     = 1'b1;
          gnt_we_d    = d_we_i;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          if (if_req_i && !starve_at_max) begin
            starve_d = starve_q + STV_W'(1);
          end
        end else if (grant_if) begin
          gnt_d_d    = 1'b0;
          gnt_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
          starve_d   = '0;
        end
        if (grant_d || grant_if) begin
          mem_en_d = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (MEM_LAT == 1) begin
          state_d  = RESP;
          if_ack_d = ~gnt_d_q;
          d_ack_d  = gnt_d_q;
        end else begin
          state_d   = WAIT;
          lat_cnt_d = CNT_W'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - CNT_W'(1);
        if (lat_cnt_d == '0) begin
          state_d  = RESP;
          if_ack_d = ~gnt_d_q;
          d_ack_d  = gnt_d_q;
        end
      end
      RESP: begin
        // mem_rdata is valid during RESP; it is bypassed to the port while
        // ack is high and latched here so the port holds it afterwards.
        state_d = IDLE;
        if (!gnt_we_q) begin
          if (gnt_d_q) begin
            d_rdata_d = mem_rdata_i;
          end else begin
            if_rdata_d = mem_rdata_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      gnt_d_q     <= 1'b0;
      gnt_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      starve_q    <= starve_d;
      gnt_d_q     <= gnt_d_d;
      gnt_we_q    <= gnt_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_d_q, perf_d_d;
  logic [31:0] perf_conf_q, perf_conf_d;

  assign perf_if_d   = (grant_if && (perf_if_q != '1)) ? perf_if_q + 32'd1 : perf_if_q;
  assign perf_d_d    = (grant_d && (perf_d_q != '1)) ? perf_d_q + 32'd1 : perf_d_q;
  assign perf_conf_d = ((grant_if || grant_d) && if_req_i && d_req_i && (perf_conf_q != '1))
                       ? perf_conf_q + 32'd1 : perf_conf_q;

  // Saturating grant and contention counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_if_q   <= '0;
      perf_d_q    <= '0;
      perf_conf_q <= '0;
    end else begin
      perf_if_q   <= perf_if_d;
      perf_d_q    <= perf_d_d;
      perf_conf_q <= perf_conf_d;
    end
  end

  assign perf_if_grants_o = perf_if_q;
  assign perf_d_grants_o  = perf_d_q;
  assign perf_conflicts_o = perf_conf_q;
`endif

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign if_rdata_o  = if_ack_q ? mem_rdata_i : if_rdata_q;
  assign d_rdata_o   = (d_ack_q && !gnt_we_q) ? mem_rdata_i : d_rdata_q;
  assign stall_if_o  = if_req_i & ~if_ack_q;
  assign stall_mem_o = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (transaction-level model plus directed literals)
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 2;

  localparam int S_EN = 0, S_WE = 1, S_ADDR = 2, S_WDATA = 3, S_IFACK = 4;
  localparam int S_IFRD = 5, S_DACK = 6, S_DRD = 7, S_STIF = 8, S_STMEM = 9;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          if_ack, d_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          stall_if, stall_mem;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_if_grants, perf_d_grants, perf_conflicts;
`endif

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
`ifdef ARB_PERF_CNT_EN
    .perf_if_grants_o(perf_if_grants), .perf_d_grants_o(perf_d_grants),
    .perf_conflicts_o(perf_conflicts),
`endif
    .stall_if_o(stall_if), .stall_mem_o(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic if_seen = 1'b0;
  logic d_seen = 1'b0;

  // Memory contents before any write; two addresses carry the directed-test values.
  function automatic logic [DW-1:0] mem_default(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'h2009_0002;
    if (a == 32'h8) return 32'h5;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Transaction-level model: a grant at cycle g owns the memory until g+LAT+2.
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic          m_busy = 1'b0;
  int            m_gnt_cyc = 0, m_ack_cyc = 0, m_next_free = 0, m_starve = 0;
  logic          m_gnt_d = 1'b0, m_gnt_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rd = '0, m_if_rdata = '0, m_d_rdata = '0;
  int            m_pif = 0, m_pd = 0, m_pconf = 0;

  // Model update at each rising edge from the request values sampled there.
  always @(posedge clk) begin
    logic gd;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_busy = 1'b0; m_next_free = 0; m_starve = 0;
      m_if_rdata = '0; m_d_rdata = '0;
      m_pif = 0; m_pd = 0; m_pconf = 0;
    end else begin
      if (m_busy && cyc == m_ack_cyc + 1) begin
        if (!m_gnt_we) begin
          if (m_gnt_d) m_d_rdata = m_rd;
          else m_if_rdata = m_rd;
        end
        m_busy = 1'b0;
      end
      if (cyc >= m_next_free && (if_req || d_req)) begin
        gd = d_req && !(if_req && m_starve == SMAX);
        if (if_req && d_req) m_pconf++;
        if (gd) begin
          m_pd++;
          if (if_req && m_starve < SMAX) m_starve++;
          m_addr = d_addr; m_gnt_we = d_we; m_wdata = d_wdata;
        end else begin
          m_pif++;
          m_starve = 0;
          m_addr = if_addr; m_gnt_we = 1'b0;
        end
        m_gnt_d = gd;
        m_busy = 1'b1;
        m_gnt_cyc = cyc;
        m_ack_cyc = cyc + LAT;
        m_next_free = cyc + LAT + 2;
        if (m_gnt_we) model_mem[m_addr] = m_wdata;
        else m_rd = model_mem.exists(m_addr) ? model_mem[m_addr] : mem_default(m_addr);
      end
    end
  end

  // Memory environment: answers reads LAT cycles after mem_en, noise otherwise.
  logic [DW-1:0] env_mem [logic [AW-1:0]];
  int            rd_due_q[$];
  logic [DW-1:0] rd_dat_q[$];
  always begin
    @(negedge clk);
    if (!rst_n) begin
      rd_due_q.delete(); rd_dat_q.delete();
    end else if (mem_en) begin
      if (mem_we) env_mem[mem_addr] = mem_wdata;
      else begin
        rd_due_q.push_back(cyc + LAT);
        rd_dat_q.push_back(env_mem.exists(mem_addr) ? env_mem[mem_addr] : mem_default(mem_addr));
      end
    end
    @(posedge clk);
    #1;
    if (rd_due_q.size() > 0 && rd_due_q[0] == cyc) begin
      mem_rdata = rd_dat_q[0];
      void'(rd_due_q.pop_front());
      void'(rd_dat_q.pop_front());
    end else begin
      mem_rdata = $urandom();
    end
  end

  int            lit_cyc [128];
  int            lit_sel [128];
  logic [31:0]   lit_val [128];
  int            lit_n = 0;

  task automatic expect_at(input int c, input int s, input logic [31:0] v);
    lit_cyc[lit_n] = c; lit_sel[lit_n] = s; lit_val[lit_n] = v;
    lit_n++;
  endtask

  function automatic logic [31:0] sig(input int s);
    case (s)
      S_EN:    return 32'(mem_en);
      S_WE:    return 32'(mem_we);
      S_ADDR:  return mem_addr;
      S_WDATA: return mem_wdata;
      S_IFACK: return 32'(if_ack);
      S_IFRD:  return if_rdata;
      S_DACK:  return 32'(d_ack);
      S_DRD:   return d_rdata;
      S_STIF:  return 32'(stall_if);
      default: return 32'(stall_mem);
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_EN:    return "lit_mem_en";
      S_WE:    return "lit_mem_we";
      S_ADDR:  return "lit_mem_addr";
      S_WDATA: return "lit_mem_wdata";
      S_IFACK: return "lit_if_ack";
      S_IFRD:  return "lit_if_rdata";
      S_DACK:  return "lit_d_ack";
      S_DRD:   return "lit_d_rdata";
      S_STIF:  return "lit_stall_if";
      default: return "lit_stall_mem";
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: actual %h required %h", nm, cyc, act, exp);
    end
  endtask

  // Compare DUT outputs against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic e_en, e_ifa, e_da;
    if (!rst_n) begin
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_if_ack", 32'(if_ack), 32'd0);
      check("rst_d_ack", 32'(d_ack), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
    end else begin
      e_en  = m_busy && (cyc == m_gnt_cyc);
      e_ifa = m_busy && (cyc == m_ack_cyc) && !m_gnt_d;
      e_da  = m_busy && (cyc == m_ack_cyc) && m_gnt_d;
      check("mem_en", 32'(mem_en), 32'(e_en));
      check("mem_we", 32'(mem_we), 32'(e_en && m_gnt_we));
      if (e_en) check("mem_addr", mem_addr, m_addr);
      if (e_en && m_gnt_we) check("mem_wdata", mem_wdata, m_wdata);
      check("if_ack", 32'(if_ack), 32'(e_ifa));
      check("d_ack", 32'(d_ack), 32'(e_da));
      check("if_rdata", if_rdata, e_ifa ? m_rd : m_if_rdata);
      check("d_rdata", d_rdata, (e_da && !m_gnt_we) ? m_rd : m_d_rdata);
      check("stall_if", 32'(stall_if), 32'(if_req && !e_ifa));
      check("stall_mem", 32'(stall_mem), 32'(d_req && !e_da));
    end
`ifdef ARB_PERF_CNT_EN
    check("perf_if_grants", perf_if_grants, 32'(m_pif));
    check("perf_d_grants", perf_d_grants, 32'(m_pd));
    check("perf_conflicts", perf_conflicts, 32'(m_pconf));
`endif
    for (int i = 0; i < lit_n; i++) begin
      if (lit_cyc[i] == cyc) check(sig_name(lit_sel[i]), sig(lit_sel[i]), lit_val[i]);
    end
    if_seen = if_ack;
    d_seen  = d_ack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = (32'($urandom_range(0, 3)) << 28) | (32'($urandom_range(0, 15)) << 2);
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = (32'($urandom_range(0, 3)) << 28) | (32'($urandom_range(0, 15)) << 2);
    d_wdata = $urandom();
  endtask

  initial begin
    int g;
    int g2;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    expect_at(cyc, S_EN, 0); expect_at(cyc, S_IFRD, 0); expect_at(cyc, S_DRD, 0);

    // Single fetch from 0x10.
    if_req = 1'b1; if_addr = 32'h10;
    g = cyc + 1;
    expect_at(g, S_EN, 1); expect_at(g, S_ADDR, 32'h10); expect_at(g, S_WE, 0);
    expect_at(g, S_STIF, 1); expect_at(g + 1, S_STIF, 1); expect_at(g + 1, S_IFACK, 0);
    expect_at(g + 2, S_IFACK, 1); expect_at(g + 2, S_IFRD, 32'h2009_0002);
    expect_at(g + 2, S_STIF, 0); expect_at(g + 3, S_IFACK, 0);
    expect_at(g + 3, S_IFRD, 32'h2009_0002);
    repeat (4) step();
    if_req = 1'b0;
    step();

    // Data write of 0xDEADBEEF to 0x40.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    g = cyc + 1;
    expect_at(g, S_EN, 1); expect_at(g, S_WE, 1); expect_at(g, S_ADDR, 32'h40);
    expect_at(g, S_WDATA, 32'hDEAD_BEEF); expect_at(g + 1, S_DACK, 0);
    expect_at(g + 2, S_DACK, 1); expect_at(g + 2, S_DRD, 0);
    repeat (4) step();
    d_req = 1'b0;
    step();

    // Data read of 0x8 with the request dropped after the grant; a fetch
    // queued meanwhile is granted only LAT+2 cycles after the read grant.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    g = cyc + 1;
    expect_at(g + 2, S_DACK, 1); expect_at(g + 2, S_DRD, 32'h5);
    expect_at(g + 3, S_DRD, 32'h5); expect_at(g + 3, S_EN, 0);
    expect_at(g + 4, S_EN, 1); expect_at(g + 4, S_ADDR, 32'h24);
    expect_at(g + 6, S_IFACK, 1);
    step();
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h24;
    repeat (7) step();
    if_req = 1'b0;
    step();

    // Both held: grants d,d,f,d,d,f with acks LAT+2 cycles apart.
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    g = cyc + 1;
    for (int k = 0; k < 6; k++) begin
      expect_at(g + k * (LAT + 2), S_ADDR, (k % 3 == 2) ? 32'h100 : 32'h200);
      expect_at(g + k * (LAT + 2) + LAT, S_DACK, (k % 3 == 2) ? 0 : 1);
      expect_at(g + k * (LAT + 2) + LAT, S_IFACK, (k % 3 == 2) ? 1 : 0);
    end
    repeat (6 * (LAT + 2)) step();
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) step();

    // Reset during WAIT abandons the read; a fresh read then completes.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    g = cyc + 1;
    repeat (2) step();
    rst_n = 1'b0; d_req = 1'b0;
    expect_at(g + 1, S_DRD, 0); expect_at(g + 1, S_ADDR, 0); expect_at(g + 1, S_EN, 0);
    for (int k = 2; k < 8; k++) begin
      expect_at(g + k, S_DACK, 0); expect_at(g + k, S_IFACK, 0);
    end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    g2 = cyc + 1;
    expect_at(g2, S_EN, 1); expect_at(g2, S_ADDR, 32'h40);
    expect_at(g2 + LAT, S_DACK, 1); expect_at(g2 + LAT, S_DRD, 32'hDEAD_BEEF);
    repeat (LAT + 2) step();
    d_req = 1'b0;
    repeat (2) step();

    // Randomized traffic; requesters hold until acked, then drop or re-request.
    for (int n = 0; n < 3000; n++) begin
      step();
      if (if_req && if_seen) begin
        if ($urandom_range(0, 1) == 1) new_if();
        else if_req = 1'b0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        new_if();
      end
      if (d_req && d_seen) begin
        if ($urandom_range(0, 1) == 1) new_d();
        else d_req = 1'b0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        new_d();
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (8) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
